mem_access_ctrl: RTL and testbench

//  Memory stage feeding the MDR: holds the MAR, a single-port word RAM and a wait-state FSM.

---
 rtl/mem_pkg.sv | 18 +
 rtl/ram_sync_sp.sv | 25 ++
 rtl/mem_access_ctrl.sv | 104 ++++++++++
 tb/tb_mem_access_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory stage: FSM encoding, default widths, wait-state limit.
package mem_pkg;

  localparam int unsigned MEM_DATA_W     = 32;
  localparam int unsigned MEM_ADDR_W     = 9;
  localparam int unsigned MEM_WAIT_MAX   = 7;
  localparam int unsigned MEM_WAIT_CNT_W = 3;

  localparam logic [1:0] MEM_IDLE   = 2'd0;
  localparam logic [1:0] MEM_ACCESS = 2'd1;
  localparam logic [1:0] MEM_DONE   = 2'd2;

  // Wait-state reload value, saturated to what the counter can hold
  function automatic logic [MEM_WAIT_CNT_W-1:0] wait_load(input int unsigned ws);
    return (ws > MEM_WAIT_MAX) ? MEM_WAIT_CNT_W'(MEM_WAIT_MAX) : MEM_WAIT_CNT_W'(ws);
  endfunction

endpackage

// File: rtl/ram_sync_sp.sv
// Single-port word RAM: clocked write with enable, registered read, no reset.
// Contents are undefined at power-up.
module ram_sync_sp
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory stage feeding the MDR: MAR, request latch, wait-state FSM and Mdatain register
// around a single-port word RAM.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_W,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  MARin,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [DATA_WIDTH-1:0] MDRout,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  req_err
);

  logic [1:0]                state, state_nxt;
  logic [MEM_WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0]     mar, addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q, rdata;
  logic                      op_q;
  logic                      accept_c, ram_we_c, err_c;
  logic                      unused_bus_hi;

  assign unused_bus_hi = ^BusMuxOut[DATA_WIDTH-1:ADDR_WIDTH];

  // State, counter, request latch and registered outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= MEM_IDLE;
      wait_cnt  <= '0;
      mar       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= 1'b0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_ready <= (state == MEM_DONE);
      busy      <= (state_nxt != MEM_IDLE);
      req_err   <= err_c;
      if (MARin) mar <= BusMuxOut[ADDR_WIDTH-1:0];
      if (accept_c) begin
        addr_q  <= mar;
        op_q    <= Write;
        wdata_q <= MDRout;
      end
      // RAM read register was loaded on the final ACCESS edge
      if (state == MEM_DONE && !op_q) Mdatain <= rdata;
    end
  end

  // Next-state and RAM strobe decode
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept_c     = 1'b0;
    ram_we_c     = 1'b0;
    err_c        = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (Read && Write) begin
          err_c = 1'b1;
        end else if (Read || Write) begin
          accept_c     = 1'b1;
          wait_cnt_nxt = wait_load(WAIT_STATES);
          state_nxt    = MEM_ACCESS;
        end
      end
      MEM_ACCESS: begin
        if (wait_cnt != '0) begin
          wait_cnt_nxt = wait_cnt - MEM_WAIT_CNT_W'(1);
        end else begin
          ram_we_c  = op_q;
          state_nxt = MEM_DONE;
        end
      end
      MEM_DONE: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  ram_sync_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (ram_we_c),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with one wait state, one with none,
// expected read data tracked through a scoreboard queue.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        MARin;
  logic [31:0] BusMuxOut;
  logic        rd1, wr1, rd0, wr0;
  logic [31:0] MDRout;
  logic [31:0] Mdatain1, Mdatain0;
  logic        mem_ready1, mem_ready0, busy1, busy0, req_err1, req_err0;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [2][512];
  logic [31:0] mdat_m [2];
  logic [8:0]  mar_m;

  always #5 clock = ~clock;

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(1)) u_dut1 (
    .clock(clock), .clear(clear), .MARin(MARin), .BusMuxOut(BusMuxOut),
    .Read(rd1), .Write(wr1), .MDRout(MDRout), .Mdatain(Mdatain1),
    .mem_ready(mem_ready1), .busy(busy1), .req_err(req_err1)
  );

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .clear(clear), .MARin(MARin), .BusMuxOut(BusMuxOut),
    .Read(rd0), .Write(wr0), .MDRout(MDRout), .Mdatain(Mdatain0),
    .mem_ready(mem_ready0), .busy(busy0), .req_err(req_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setmar(input logic [31:0] a);
    MARin     = 1'b1;
    BusMuxOut = a;
    tick();
    MARin     = 1'b0;
    mar_m     = a[8:0];
  endtask

  // sel=1 drives the one-wait-state instance, sel=0 the zero-wait one.
  // mode 1: reload MAR/MDRout mid-access; mode 2: raise Write while busy.
  task automatic access(input bit sel, input bit is_wr, input int mode, input string tag);
    int          n;
    logic [31:0] exp;
    if (is_wr) begin
      mdl[sel][mar_m] = MDRout;
      exp_q.push_back(mdat_m[sel]);
    end else begin
      exp_q.push_back(mdl[sel][mar_m]);
      mdat_m[sel] = mdl[sel][mar_m];
    end
    if (sel) begin wr1 = is_wr; rd1 = !is_wr; end
    else     begin wr0 = is_wr; rd0 = !is_wr; end
    tick();
    rd1 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    chk({tag, "_busy"}, 32'(sel ? busy1 : busy0), 32'd1);
    n = 1;
    while ((sel ? mem_ready1 : mem_ready0) !== 1'b1 && n < 20) begin
      if (mode == 1 && n == 1) begin
        MARin = 1'b1; BusMuxOut = 32'hFFFF_F1FF; MDRout = 32'h0;
      end
      if (mode == 1 && n == 2) MARin = 1'b0;
      if (mode == 2 && n == 1) begin wr1 = 1'b1; MDRout = 32'h1111_1111; end
      if (mode == 2 && n == 3) wr1 = 1'b0;
      tick();
      n++;
    end
    if (mode == 1) mar_m = 9'h1FF;
    chk({tag, "_latency"}, 32'(n), sel ? 32'd4 : 32'd3);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    chk({tag, "_data"}, sel ? Mdatain1 : Mdatain0, exp);
    chk({tag, "_idle"}, 32'(sel ? busy1 : busy0), 32'd0);
    tick();
    chk({tag, "_pulse"}, 32'(sel ? mem_ready1 : mem_ready0), 32'd0);
  endtask

  initial begin
    int seen;
    clear = 1'b0; MARin = 1'b0; BusMuxOut = '0; MDRout = '0;
    rd1 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    mdat_m[0] = '0; mdat_m[1] = '0; mar_m = '0;
    tick(); tick();
    chk("rst_ready", 32'(mem_ready1), 32'd0);
    chk("rst_busy",  32'(busy1),      32'd0);
    chk("rst_err",   32'(req_err1),   32'd0);
    chk("rst_mdat",  Mdatain1,        32'd0);
    clear = 1'b1;
    tick();

    // Basic write then read back
    setmar(32'h005); MDRout = 32'hDEAD_BEEF;
    access(1'b1, 1'b1, 0, "wr5");
    access(1'b1, 1'b0, 0, "rd5");
    setmar(32'h010); MDRout = 32'h0BAD_C0DE;
    access(1'b1, 1'b1, 0, "wr10");

    // Address and write data latched at acceptance
    setmar(32'h005); MDRout = 32'h2222_2222;
    access(1'b1, 1'b0, 1, "rd5_dist");
    MDRout = 32'hCAFE_F00D;
    access(1'b1, 1'b1, 0, "wr1ff");
    setmar(32'h005);
    access(1'b1, 1'b0, 0, "rd5_again");
    setmar(32'h1FF);
    access(1'b1, 1'b0, 0, "rd1ff");

    // Conflicting request and requests while busy
    rd1 = 1'b1; wr1 = 1'b1;
    tick();
    rd1 = 1'b0; wr1 = 1'b0;
    chk("conf_err",  32'(req_err1), 32'd1);
    chk("conf_busy", 32'(busy1),    32'd0);
    tick();
    chk("conf_err_pulse", 32'(req_err1),   32'd0);
    chk("conf_noready",   32'(mem_ready1), 32'd0);
    chk("conf_nobusy",    32'(busy1),      32'd0);
    setmar(32'h005);
    access(1'b1, 1'b0, 2, "rd5_busywr");
    access(1'b1, 1'b0, 0, "rd5_after");

    // Reset in the middle of a write aborts it
    setmar(32'h010); MDRout = 32'h1234_5678;
    wr1 = 1'b1;
    tick();
    wr1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("abort_busy0",  32'(busy1),      32'd0);
    chk("abort_ready0", 32'(mem_ready1), 32'd0);
    chk("abort_err0",   32'(req_err1),   32'd0);
    chk("abort_mdat0",  Mdatain1,        32'd0);
    mdat_m[1] = '0;
    mar_m     = '0;
    tick();
    clear = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (mem_ready1) seen++;
    end
    chk("abort_noready", 32'(seen), 32'd0);
    setmar(32'h010);
    access(1'b1, 1'b0, 0, "rd10_kept");
    setmar(32'h005);
    access(1'b1, 1'b0, 0, "rd5_kept");

    // Zero wait states at the top address
    setmar(32'h1FF); MDRout = 32'hA5A5_A5A5;
    access(1'b0, 1'b1, 0, "ws0_wr");
    access(1'b0, 1'b0, 0, "ws0_rd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
